// File: rtl/reg_load_arbiter.sv
// Round-robin load/clear sequencer for one shared register: req at edge N drives gnt/reg_en in cycle N..N+1.
// Requesters hold req until granted; a clear arriving while busy is remembered and served first at the next IDLE.
module reg_load_arbiter #(
    parameter int NREQ        = 4,
    parameter int WIDTH       = 4,
    parameter int HOLD_CYCLES = 1,
    parameter int ID_W        = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] req_data,
    input  logic                  clr_req,
    output logic [NREQ-1:0]       gnt,
    output logic [WIDTH-1:0]      reg_d,
    output logic                  reg_en,
    output logic                  reg_clr,
    output logic                  busy,
    output logic [ID_W-1:0]       last_id
);

    typedef enum logic [1:0] {IDLE, LOAD, CLEAR, GAP} state_t;

    localparam logic [3:0] HOLD = 4'(HOLD_CYCLES);

    state_t          state;
    logic [ID_W-1:0] rr_ptr;
    logic            clr_pend;
    logic [3:0]      gap_cnt;

    logic            win_vld;
    logic [ID_W-1:0] win_id;
    logic [ID_W-1:0] win_next;

    // Search starts at rr_ptr and wraps, so the last winner has lowest priority next time.
    always_comb begin
        int idx;
        idx     = 0;
        win_vld = 1'b0;
        win_id  = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!win_vld && req[idx]) begin
                win_vld = 1'b1;
                win_id  = ID_W'(idx);
            end
        end
    end

    assign win_next = (win_id == ID_W'(NREQ - 1)) ? '0 : win_id + ID_W'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            clr_pend <= 1'b0;
            gap_cnt  <= '0;
            gnt      <= '0;
            reg_d    <= '0;
            reg_en   <= 1'b0;
            reg_clr  <= 1'b0;
            busy     <= 1'b0;
            last_id  <= '0;
        end else begin
            if (clr_req && state != IDLE) begin
                clr_pend <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (clr_req || clr_pend) begin
                        state    <= CLEAR;
                        clr_pend <= 1'b0;
                        reg_clr  <= 1'b1;
                        busy     <= 1'b1;
                    end else if (win_vld) begin
                        state   <= LOAD;
                        gnt     <= NREQ'(1) << win_id;
                        reg_en  <= 1'b1;
                        reg_d   <= req_data[win_id*WIDTH +: WIDTH];
                        last_id <= win_id;
                        rr_ptr  <= win_next;
                        busy    <= 1'b1;
                    end
                end
                LOAD, CLEAR: begin
                    gnt     <= '0;
                    reg_en  <= 1'b0;
                    reg_clr <= 1'b0;
                    if (HOLD != 4'd0) begin
                        state   <= GAP;
                        gap_cnt <= HOLD;
                        busy    <= 1'b1;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                GAP: begin
                    if (gap_cnt <= 4'd1) begin
                        state   <= IDLE;
                        gap_cnt <= '0;
                        busy    <= 1'b0;
                    end else begin
                        gap_cnt <= gap_cnt - 4'd1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    gnt     <= '0;
                    reg_en  <= 1'b0;
                    reg_clr <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
